// File: rtl/prbs31_checker.sv
// ----------------------------------------------------------------------------
// prbs31_checker
//   Serial PRBS31 (x^31 + x^28 + 1) stream checker. The checker self-synchronises
//   by loading 31 received bits into its history. It then verifies 64
//   consecutive predicted bits. After that it reports bit errors while locked,
//   and drops lock when too many errors fall into one 256-sample window.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   ena      in   powered indication (ignored)
//   ui_in    in   [0]=data  [1]=valid strobe  [2]=clr err_cnt  [7:3] unused
//   uio_in   in   unused
//   uo_out   out  [0]=lock  [1]=err pulse  [2]=sat  [3]=hunt  [7:4]=0
//   uio_out  out  err_cnt when PRBS_CHK_CNT_OUT_EN is defined, else 0
//   uio_oe   out  8'hFF when PRBS_CHK_CNT_OUT_EN is defined, else 0
//
// Build option
//   PRBS_CHK_CNT_OUT_EN : drive err_cnt onto the bidirectional pins.
// ----------------------------------------------------------------------------
module prbs31_checker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [30:0] h;          // h[0] = newest received bit
    logic [4:0]  fill_cnt;
    logic [5:0]  match_cnt;
    logic [7:0]  win_cnt;
    logic [3:0]  win_err;
    logic [7:0]  err_cnt;
    logic        err;
    logic        lock, hunt, sat;

    logic data, valid, clr;
    assign data  = ui_in[0];
    assign valid = ui_in[1];
    assign clr   = ui_in[2];

    // Pins the block never looks at.
    logic unused_in;
    assign unused_in = &{1'b0, ena, uio_in, ui_in[7:3]};

    // Prediction uses the history before this sample shifts in.
    logic pred, mismatch;
    assign pred     = h[30] ^ h[27];
    assign mismatch = valid && (data != pred);

    // The sample seen while win_cnt is 255 opens a new window, so it counts
    // against a fresh error budget.
    logic [3:0] win_err_nxt;
    logic       win_trip;
    assign win_err_nxt = ((win_cnt == 8'hFF) ? 4'd0 : win_err) + {3'd0, mismatch};
    assign win_trip    = (state == LOCKED) && mismatch && (win_err_nxt == 4'd8);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (valid) begin
            case (state)
                FILL:    if (fill_cnt == 5'd30) state_nxt = VERIFY;
                // An all-zero history predicts zeros forever. Refuse to lock on it.
                VERIFY:  if ((h == '0) || mismatch)  state_nxt = FILL;
                         else if (match_cnt == 6'd63) state_nxt = LOCKED;
                LOCKED:  if (win_trip) state_nxt = FILL;
                default: state_nxt = FILL;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        lock = (state == LOCKED);
        hunt = (state == FILL);
    end

    // ---------------- datapath / counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            err <= (state == LOCKED) && mismatch;

            if (clr)
                err_cnt <= '0;
            else if ((state == LOCKED) && mismatch && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;

            if (valid) begin
                h <= {h[29:0], data};
                // Each counter restarts whenever its state is entered or left.
                fill_cnt  <= ((state == FILL) && (state_nxt == FILL))
                             ? fill_cnt + 5'd1 : 5'd0;
                match_cnt <= ((state == VERIFY) && (state_nxt == VERIFY))
                             ? match_cnt + 6'd1 : 6'd0;
                if ((state == LOCKED) && (state_nxt == LOCKED)) begin
                    win_cnt <= win_cnt + 8'd1;
                    win_err <= win_err_nxt;
                end else begin
                    win_cnt <= '0;
                    win_err <= '0;
                end
            end
        end
    end

    assign sat    = (err_cnt == 8'hFF);
    assign uo_out = {4'd0, hunt, sat, err, lock};

`ifdef PRBS_CHK_CNT_OUT_EN
    assign uio_out = err_cnt;
    assign uio_oe  = 8'hFF;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
module tb_prbs31_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int checks = 0;
    int failures = 0;

    prbs31_checker dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum int {M_FILL, M_VERIFY, M_LOCKED} mstate_t;
    mstate_t m_state;
    int      m_fill, m_match, m_lsamp, m_werr, m_errcnt;
    bit      m_err;
    bit      mh[$];   // last 31 received bits, index 0 = oldest
    bit      g[$];    // stimulus generator history, index 0 = oldest

    function automatic void m_reset();
        m_state = M_FILL; m_fill = 0; m_match = 0; m_lsamp = 0; m_werr = 0;
        m_errcnt = 0; m_err = 0;
        mh.delete();
        for (int i = 0; i < 31; i++) mh.push_back(1'b0);
    endfunction

    function automatic void m_step(bit d, bit v, bit c);
        bit mm, zero;
        m_err = 0;
        if (v) begin
            mm = (d != (mh[0] ^ mh[3]));   // bits 31 and 28 samples ago
            zero = 1;
            foreach (mh[i]) if (mh[i]) zero = 0;
            case (m_state)
                M_FILL: begin
                    m_fill++;
                    if (m_fill == 31) begin m_state = M_VERIFY; m_match = 0; end
                end
                M_VERIFY: begin
                    if (zero || mm) begin m_state = M_FILL; m_fill = 0; end
                    else begin
                        m_match++;
                        if (m_match == 64) begin m_state = M_LOCKED; m_lsamp = 0; m_werr = 0; end
                    end
                end
                default: begin
                    if (m_lsamp % 256 == 255) m_werr = 0;
                    m_lsamp++;
                    if (mm) begin
                        m_err = 1;
                        if (m_errcnt < 255) m_errcnt++;
                        m_werr++;
                        if (m_werr == 8) begin m_state = M_FILL; m_fill = 0; m_werr = 0; end
                    end
                end
            endcase
            void'(mh.pop_front());
            mh.push_back(d);
        end
        if (c) m_errcnt = 0;
    endfunction

    function automatic logic [7:0] m_uo();
        return {4'd0, (m_state == M_FILL), (m_errcnt == 255), m_err, (m_state == M_LOCKED)};
    endfunction

    function automatic logic [7:0] m_uio_out();
`ifdef PRBS_CHK_CNT_OUT_EN
        return 8'(m_errcnt);
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [7:0] m_uio_oe();
`ifdef PRBS_CHK_CNT_OUT_EN
        return 8'hFF;
`else
        return 8'h00;
`endif
    endfunction

    // PRBS31 generator seeded with 31'd1 (seed bit 0 is the newest).
    function automatic void gen_seed();
        g.delete();
        for (int i = 0; i < 30; i++) g.push_back(1'b0);
        g.push_back(1'b1);
    endfunction

    function automatic bit gen_next();
        bit b;
        b = g[0] ^ g[3];
        void'(g.pop_front());
        g.push_back(b);
        return b;
    endfunction

    // ---------------- drivers ----------------
    task automatic cyc(input bit d, input bit v, input bit c);
        ui_in = {5'd0, c, v, d};
        @(posedge clk); #1;
        m_step(d, v, c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic clean_bits(input int n);
        for (int i = 0; i < n; i++) cyc(gen_next(), 1'b1, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        uio_in = 8'($urandom);
        do_reset();
        checks++;
        if (uo_out !== 8'h08) begin failures++; $display("FAIL reset_uo got=%h exp=08", uo_out); end
        checks++;
        if (uio_out !== 8'h00) begin failures++; $display("FAIL reset_uio_out got=%h exp=00", uio_out); end
        checks++;
        if (uio_oe !== m_uio_oe()) begin failures++; $display("FAIL reset_uio_oe got=%h exp=%h", uio_oe, m_uio_oe()); end
        checks++;
        if (dut.err_cnt !== 8'd0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", dut.err_cnt); end
        // Invalid samples with random data and no clear must leave everything untouched.
        for (int i = 0; i < 40; i++) begin
            cyc(1'($urandom), 1'b0, 1'b0);
            checks++;
            if (uo_out !== 8'h08) begin failures++; $display("FAIL idle_uo i=%0d got=%h exp=08", i, uo_out); end
        end
    endtask

    task automatic test_clean_lock();
        do_reset();
        gen_seed();
        for (int i = 1; i <= 10000; i++) begin
            cyc(gen_next(), 1'b1, 1'b0);
            checks++;
            if (uo_out !== m_uo()) begin failures++; $display("FAIL clean_uo i=%0d got=%h exp=%h", i, uo_out, m_uo()); end
            if (i == 30) begin
                checks++;
                if (uo_out[3] !== 1'b1) begin failures++; $display("FAIL clean_hunt30 got=%b exp=1", uo_out[3]); end
            end
            if (i == 31) begin
                checks++;
                if (uo_out[3] !== 1'b0) begin failures++; $display("FAIL clean_hunt31 got=%b exp=0", uo_out[3]); end
            end
            if (i == 94) begin
                checks++;
                if (uo_out[0] !== 1'b0) begin failures++; $display("FAIL clean_lock94 got=%b exp=0", uo_out[0]); end
            end
            if (i == 95) begin
                checks++;
                if (uo_out[0] !== 1'b1) begin failures++; $display("FAIL clean_lock95 got=%b exp=1", uo_out[0]); end
            end
        end
        checks++;
        if (dut.err_cnt !== 8'd0) begin failures++; $display("FAIL clean_errcnt got=%0d exp=0", dut.err_cnt); end
    endtask

    task automatic test_single_flip();
        int pulses;
        bit b, exp_err;
        pulses = 0;
        do_reset();
        gen_seed();
        clean_bits(100);
        for (int k = 0; k < 60; k++) begin
            b = gen_next();
            if (k == 0) b = ~b;
            cyc(b, 1'b1, 1'b0);
            exp_err = (k == 0) || (k == 28) || (k == 31);
            if (uo_out[1]) pulses++;
            checks++;
            if (uo_out[1] !== exp_err || uo_out[0] !== 1'b1) begin
                failures++; $display("FAIL flip_err_lock k=%0d got=%b%b exp=1%b", k, uo_out[0], uo_out[1], exp_err);
            end
        end
        checks++;
        if (pulses != 3) begin failures++; $display("FAIL flip_pulses got=%0d exp=3", pulses); end
        checks++;
        if (dut.err_cnt !== 8'd3) begin failures++; $display("FAIL flip_errcnt got=%0d exp=3", dut.err_cnt); end
    endtask

    task automatic test_window();
        int fall;
        bit b;
        fall = -1;
        do_reset();
        gen_seed();
        clean_bits(100);
        for (int k = 0; k < 220; k++) begin
            b = gen_next();
            if (k == 0 || k == 40 || k == 80) b = ~b;
            cyc(b, 1'b1, 1'b0);
            if (fall < 0 && !uo_out[0]) fall = k;
            checks++;
            if (uo_out !== m_uo()) begin failures++; $display("FAIL win_uo k=%0d got=%h exp=%h", k, uo_out, m_uo()); end
            if (k == 120) begin
                checks++;
                if (dut.err_cnt !== 8'd8 || uo_out[3] !== 1'b1) begin
                    failures++; $display("FAIL win_drop errcnt=%0d hunt=%b exp 8/1", dut.err_cnt, uo_out[3]);
                end
            end
            if (k == 202) begin
                checks++;
                if (uo_out[0] !== 1'b0) begin failures++; $display("FAIL win_relock202 got=%b exp=0", uo_out[0]); end
            end
            if (k == 203) begin
                checks++;
                if (uo_out[0] !== 1'b1) begin failures++; $display("FAIL win_relock203 got=%b exp=1", uo_out[0]); end
            end
        end
        checks++;
        if (fall != 108) begin failures++; $display("FAIL win_fall got=%0d exp=108", fall); end
    endtask

    task automatic test_stuck();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int i = 0; i < 1000; i++) begin
                cyc(pass[0], 1'b1, 1'b0);
                checks++;
                if (uo_out[0] !== 1'b0 || uo_out !== m_uo()) begin
                    failures++; $display("FAIL stuck%0d i=%0d got=%h exp=%h", pass, i, uo_out, m_uo());
                end
            end
        end
    endtask

    task automatic test_valid_toggle_clr();
        int nv;
        bit v, d, flipped;
        nv = 0;
        flipped = 0;
        do_reset();
        gen_seed();
        for (int c = 0; c < 280; c++) begin
            v = (c % 2 == 0);
            d = v ? gen_next() : 1'($urandom);
            // One corrupted bit once lock is established.
            if (v && c >= 200 && !flipped) begin d = ~d; flipped = 1; end
            cyc(d, v, 1'b0);
            nv += int'(v);
            checks++;
            if (uo_out[0] !== (nv >= 95) || uo_out !== m_uo()) begin
                failures++; $display("FAIL toggle c=%0d got=%h exp_lock=%0b", c, uo_out, (nv >= 95));
            end
        end
        checks++;
        if (dut.err_cnt !== 8'd3) begin failures++; $display("FAIL toggle_errcnt got=%0d exp=3", dut.err_cnt); end
        cyc(1'b0, 1'b0, 1'b1);
        checks++;
        if (dut.err_cnt !== 8'd0 || uo_out[0] !== 1'b1) begin
            failures++; $display("FAIL clr errcnt=%0d lock=%b exp 0/1", dut.err_cnt, uo_out[0]);
        end
    endtask

    task automatic test_reset_mid_lock();
        bit b;
        do_reset();
        gen_seed();
        clean_bits(100);
        for (int k = 0; k < 40; k++) begin
            b = gen_next();
            if (k == 0) b = ~b;
            cyc(b, 1'b1, 1'b0);
        end
        checks++;
        if (dut.err_cnt !== 8'd3 || uo_out[0] !== 1'b1) begin
            failures++; $display("FAIL midrst_pre errcnt=%0d lock=%b exp 3/1", dut.err_cnt, uo_out[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h08 || dut.err_cnt !== 8'd0 || uio_out !== 8'h00) begin
            failures++; $display("FAIL midrst uo=%h errcnt=%0d uio=%h exp 08/0/00", uo_out, dut.err_cnt, uio_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_saturate();
        bit b;
        do_reset();
        gen_seed();
        clean_bits(95);
        // One flip per 128 samples keeps each window at six errors.
        for (int n = 0; n < 90; n++) begin
            for (int k = 0; k < 128; k++) begin
                b = gen_next();
                if (k == 0) b = ~b;
                cyc(b, 1'b1, 1'b0);
                checks++;
                if (uo_out !== m_uo() || dut.err_cnt !== 8'(m_errcnt)) begin
                    failures++; $display("FAIL sat_run n=%0d k=%0d uo=%h exp=%h cnt=%0d exp=%0d",
                                         n, k, uo_out, m_uo(), dut.err_cnt, m_errcnt);
                end
            end
        end
        checks++;
        if (dut.err_cnt !== 8'd255 || uo_out[2] !== 1'b1 || uo_out[0] !== 1'b1) begin
            failures++; $display("FAIL sat_end cnt=%0d sat=%b lock=%b exp 255/1/1", dut.err_cnt, uo_out[2], uo_out[0]);
        end
        cyc(gen_next(), 1'b1, 1'b1);
        checks++;
        if (uo_out[2] !== 1'b0 || dut.err_cnt !== 8'd0) begin
            failures++; $display("FAIL sat_clr sat=%b cnt=%0d exp 0/0", uo_out[2], dut.err_cnt);
        end
    endtask

    task automatic test_random();
        bit v, d, c;
        do_reset();
        gen_seed();
        for (int i = 0; i < 4000; i++) begin
            v = ($urandom % 4) != 0;
            c = ($urandom % 150) == 0;
            d = v ? gen_next() : 1'($urandom);
            if (v && ($urandom % 40) == 0) d = ~d;
            cyc(d, v, c);
            checks++;
            if (uo_out !== m_uo() || uio_out !== m_uio_out() || uio_oe !== m_uio_oe()
                || dut.err_cnt !== 8'(m_errcnt)) begin
                failures++; $display("FAIL rand i=%0d uo=%h/%h uio=%h/%h cnt=%0d/%0d",
                                     i, uo_out, m_uo(), uio_out, m_uio_out(), dut.err_cnt, m_errcnt);
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_window();
        test_stuck();
        test_valid_toggle_clr();
        test_reset_mid_lock();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
